// File: rtl/sched_pkg.sv
// sched_pkg: shared slot state encoding and width helpers for the issue scheduler.
package sched_pkg;
  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_READY, S_ISSUED} slot_state_e;
  function automatic int lncommit(int n);
    return $clog2(n);
  endfunction
  // Busy counter holds up to UNIT_LAT-1; keep at least one bit for UNIT_LAT=1.
  function automatic int busy_w(int lat);
    return lat > 1 ? $clog2(lat) : 1;
  endfunction
endpackage

// File: rtl/commit_rot.sv
// commit_rot: rotate-right barrel rotator, dout[j] = din[(j + amt) mod NCOMMIT].
module commit_rot
  import sched_pkg::*;
#(
  parameter int NCOMMIT  = 32,
  parameter int LNCOMMIT = lncommit(NCOMMIT)
) (
  input  logic [NCOMMIT-1:0]  din,
  input  logic [LNCOMMIT-1:0] amt,
  output logic [NCOMMIT-1:0]  dout
);
  always_comb begin
    dout = '0;
    for (int j = 0; j < NCOMMIT; j++) dout[j] = din[LNCOMMIT'(LNCOMMIT'(j) + amt)];
  end
endmodule

// File: rtl/issue_sched.sv
// issue_sched: per-slot issue state tracking and age-ordered selection onto NUNIT execution units.
module issue_sched
  import sched_pkg::*;
#(
  parameter int NCOMMIT  = 32,
  parameter int LNCOMMIT = lncommit(NCOMMIT),
  parameter int NUNIT    = 2,
  parameter int UNIT_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NCOMMIT-1:0]        alloc_valid,
  input  logic [NCOMMIT-1:0]        alloc_ready,
  input  logic [NCOMMIT-1:0]        wake,
  input  logic                      replay_valid,
  input  logic [LNCOMMIT-1:0]       replay_addr,
  input  logic [NCOMMIT-1:0]        free,
  input  logic [NCOMMIT-1:0]        kill,
  input  logic                      flush,
  input  logic [LNCOMMIT-1:0]       commit_head,
  input  logic [NUNIT-1:0]          unit_stall,
  output logic [NUNIT-1:0]          issue_valid,
  output logic [NUNIT*LNCOMMIT-1:0] issue_addr
);
  localparam int BW = busy_w(UNIT_LAT);
  localparam logic [BW-1:0] BUSY_LOAD = BW'(UNIT_LAT - 1);
  slot_state_e state_q [NCOMMIT];
  slot_state_e state_d [NCOMMIT];
  logic [BW-1:0] busy_q [NUNIT];
  logic [BW-1:0] busy_d [NUNIT];
  logic [NUNIT-1:0] issue_valid_q, issue_valid_d;
  logic [NUNIT*LNCOMMIT-1:0] issue_addr_q, issue_addr_d;
  logic [NCOMMIT-1:0] ready_vec, ready_rot, rem, sel_rot, sel;
  logic [LNCOMMIT-1:0] unrot_amt, idx;
  logic [LNCOMMIT-1:0] gaddr [NUNIT];
  logic [NUNIT-1:0] grant;
  logic hit;
  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < NCOMMIT; i++) ready_vec[i] = state_q[i] == S_READY;
  end
  assign unrot_amt = LNCOMMIT'(0) - commit_head;
  commit_rot #(.NCOMMIT(NCOMMIT), .LNCOMMIT(LNCOMMIT)) u_rot_in (
    .din(ready_vec), .amt(commit_head), .dout(ready_rot)
  );
  commit_rot #(.NCOMMIT(NCOMMIT), .LNCOMMIT(LNCOMMIT)) u_rot_back (
    .din(sel_rot), .amt(unrot_amt), .dout(sel)
  );
  // Priority chain: each available unit, lowest index first, takes the oldest remaining READY slot.
  always_comb begin
    rem = ready_rot;
    grant = '0;
    hit = 1'b0;
    idx = '0;
    for (int u = 0; u < NUNIT; u++) begin
      gaddr[u] = '0;
      hit = 1'b0;
      idx = '0;
      for (int j = NCOMMIT - 1; j >= 0; j--) begin
        if (rem[j]) begin
          hit = 1'b1;
          idx = LNCOMMIT'(j);
        end
      end
      if (hit && !unit_stall[u] && busy_q[u] == '0) begin
        rem[idx] = 1'b0;
        grant[u] = 1'b1;
        gaddr[u] = idx + commit_head;
      end
    end
    sel_rot = ready_rot & ~rem;
  end
  always_comb begin
    issue_valid_d = '0;
    issue_addr_d = '0;
    for (int u = 0; u < NUNIT; u++) begin
      issue_valid_d[u] = grant[u] && !kill[gaddr[u]] && !flush;
      issue_addr_d[u*LNCOMMIT +: LNCOMMIT] = issue_valid_d[u] ? gaddr[u] : '0;
      busy_d[u] = flush ? '0 : issue_valid_d[u] ? BUSY_LOAD : busy_q[u] != '0 ? busy_q[u] - 1'b1 : '0;
    end
  end
  always_comb begin
    for (int i = 0; i < NCOMMIT; i++) begin
      state_d[i] = (flush || kill[i] || free[i]) ? S_EMPTY :
                   alloc_valid[i] ? (alloc_ready[i] ? S_READY : S_WAIT) :
                   (replay_valid && replay_addr == LNCOMMIT'(i) && state_q[i] == S_ISSUED) ? S_READY :
                   sel[i] ? S_ISSUED :
                   (wake[i] && state_q[i] == S_WAIT) ? S_READY : state_q[i];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCOMMIT; i++) state_q[i] <= S_EMPTY;
      for (int u = 0; u < NUNIT; u++) busy_q[u] <= '0;
      issue_valid_q <= '0;
      issue_addr_q <= '0;
    end else begin
      for (int i = 0; i < NCOMMIT; i++) state_q[i] <= state_d[i];
      for (int u = 0; u < NUNIT; u++) busy_q[u] <= busy_d[u];
      issue_valid_q <= issue_valid_d;
      issue_addr_q <= issue_addr_d;
    end
  end
  assign issue_valid = issue_valid_q;
  assign issue_addr = issue_addr_q;
endmodule
